// File: rtl/dcache_pkg.sv
// Shared geometry, controller state encoding and byte-select helper for the
// direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W   = 8;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;
  localparam int BLOCK_W  = 8 << OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    FETCH,
    UPDATE
  } state_e;

  // Byte 0 lives in bits [7:0]; offset 3 selects [31:24].
  function automatic logic [7:0] byte_sel(input logic [BLOCK_W-1:0]  blk,
                                          input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_ctrl_fsm.sv
// Miss controller: sequences write-back and fetch against the block memory,
// captures the fetched block and strobes the line update.
module dcache_ctrl_fsm
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic               hit_i,
  input  logic               evict_i,
  input  logic               mem_busywait_i,
  input  logic [BLOCK_W-1:0] mem_readdata_i,
  output logic [1:0]         state_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               update_o,
  output logic [BLOCK_W-1:0] fill_o
);

  state_e             state_q;
  logic               seen_busy_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic               update_q;
  logic [BLOCK_W-1:0] fill_q;
  logic               mem_done;

  // A memory transaction only completes on a 1->0 busy transition.
  assign mem_done = seen_busy_q && !mem_busywait_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      seen_busy_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      update_q    <= 1'b0;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i && !hit_i) begin
            seen_busy_q <= 1'b0;
            if (evict_i) begin
              state_q     <= WRITE_BACK;
              mem_write_q <= 1'b1;
            end else begin
              state_q    <= FETCH;
              mem_read_q <= 1'b1;
            end
          end
        end
        WRITE_BACK: begin
          if (mem_done) begin
            state_q     <= FETCH;
            seen_busy_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
          end else if (mem_busywait_i) begin
            seen_busy_q <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_done) begin
            state_q     <= UPDATE;
            seen_busy_q <= 1'b0;
            mem_read_q  <= 1'b0;
            update_q    <= 1'b1;
          end else if (mem_busywait_i) begin
            seen_busy_q <= 1'b1;
          end
        end
        UPDATE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == FETCH && mem_done) begin
      fill_q <= mem_readdata_i;
    end
  end

  assign state_o     = state_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign update_o    = update_q;
  assign fill_o      = fill_q;

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back data cache: tag/data arrays, hit logic and the
// CPU-side load/store datapath around the miss controller.
module dcache_direct_mapped
  import dcache_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     read_i,
  input  logic                     write_i,
  input  logic [ADDR_W-1:0]        address_i,
  input  logic [7:0]               writedata_i,
  output logic [7:0]               readdata_o,
  output logic                     busywait_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic [TAG_W+INDEX_W-1:0] mem_address_o,
  output logic [BLOCK_W-1:0]       mem_writedata_o,
  input  logic [BLOCK_W-1:0]       mem_readdata_i,
  input  logic                     mem_busywait_i
);

  logic [BLOCK_W-1:0]  block_q [LINES];
  logic [TAG_W-1:0]    tag_q   [LINES];
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic [TAG_W-1:0]    miss_tag_q;
  logic [INDEX_W-1:0]  miss_idx_q;

  logic [1:0]          state;
  logic                idle;
  logic                req;
  logic                hit;
  logic                write_hit;
  logic                update;
  logic [BLOCK_W-1:0]  fill;
  logic [7:0]          readdata_q;
  logic [7:0]          readdata_d;

  assign {req_tag, req_idx, req_off} = address_i;

  assign req       = read_i || write_i;
  assign idle      = (state == IDLE);
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign write_hit = idle && write_i && hit;
  assign busywait_o = rst_ni && req && (!hit || !idle);

  dcache_ctrl_fsm u_ctrl (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req),
    .hit_i          (hit),
    .evict_i        (valid_q[req_idx] && dirty_q[req_idx]),
    .mem_busywait_i (mem_busywait_i),
    .mem_readdata_i (mem_readdata_i),
    .state_o        (state),
    .mem_read_o     (mem_read_o),
    .mem_write_o    (mem_write_o),
    .update_o       (update),
    .fill_o         (fill)
  );

  // The miss address is frozen when the controller leaves IDLE so the fill
  // lands in the right line even if the CPU drops its request mid-miss.
  always_ff @(posedge clk_i) begin
    if (idle) begin
      miss_tag_q <= req_tag;
      miss_idx_q <= req_idx;
    end
  end

  assign mem_address_o   = (state == WRITE_BACK) ? {tag_q[miss_idx_q], miss_idx_q}
                                                 : {miss_tag_q, miss_idx_q};
  assign mem_writedata_o = block_q[miss_idx_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (update) begin
      valid_q[miss_idx_q] <= 1'b1;
      dirty_q[miss_idx_q] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (update) begin
      block_q[miss_idx_q] <= fill;
      tag_q[miss_idx_q]   <= miss_tag_q;
    end else if (write_hit) begin
      block_q[req_idx][{req_off, 3'b000} +: 8] <= writedata_i;
    end
  end

  // Load data is combinational on a hit and otherwise holds the last value.
  assign readdata_d = (read_i && hit) ? byte_sel(block_q[req_idx], req_off) : readdata_q;
  assign readdata_o = readdata_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      readdata_q <= 8'h00;
    end else begin
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Scoreboard bench for the direct-mapped data cache with a slow block-memory model.
module tb_dcache_direct_mapped;

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mr;
  logic        mw;
  logic [5:0]  maddr;
  logic [31:0] mwdata;
  logic [31:0] mrdata;
  logic        mbusy;

  dcache_direct_mapped dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .read_i          (rd),
    .write_i         (wr),
    .address_i       (addr),
    .writedata_i     (wdata),
    .readdata_o      (readdata),
    .busywait_o      (busywait),
    .mem_read_o      (mr),
    .mem_write_o     (mw),
    .mem_address_o   (maddr),
    .mem_writedata_o (mwdata),
    .mem_readdata_i  (mrdata),
    .mem_busywait_i  (mbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       chk;
    int         stall;
  } cpu_exp_t;

  typedef struct {
    logic        is_wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } mem_exp_t;

  cpu_exp_t    cpu_q[$];
  mem_exp_t    mem_q[$];
  int          checks;
  int          failures;
  int          pre_idle;
  int          busy_len;
  logic        mem_active;
  logic [31:0] backing [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic w, input logic [5:0] a, input logic [31:0] d);
    mem_exp_t e;
    e.is_wr = w;
    e.addr  = a;
    e.wdata = d;
    mem_q.push_back(e);
  endtask

  // Called just after a posedge; holds the request until BUSYWAIT is low at a negedge.
  task automatic cpu_op(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] exp_d, input int exp_stall);
    cpu_exp_t e;
    int n;
    e.data  = exp_d;
    e.chk   = r && !w;
    e.stall = exp_stall;
    cpu_q.push_back(e);
    rd = r; wr = w; addr = a; wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busywait && n < 100);
    if (busywait) begin
      checks++;
      failures++;
      $display("FAIL cpu_timeout addr=%h busywait=%b required=0", a, busywait);
    end
    @(posedge clk); #2;
    rd = 1'b0; wr = 1'b0;
  endtask

  // Block memory: optional idle lead-in, then busy for busy_len sampled edges.
  initial begin
    logic        t_wr;
    logic [5:0]  t_a;
    logic [31:0] t_d;
    mbusy = 1'b0; mrdata = '0; mem_active = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mr || mw) begin
        mem_active = 1'b1;
        t_wr = mw; t_a = maddr; t_d = mwdata;
        repeat (pre_idle) begin @(posedge clk); #1; end
        mbusy = 1'b1;
        repeat (busy_len) begin @(posedge clk); #1; end
        mbusy = 1'b0;
        if (t_wr) backing[t_a] = t_d;
        else      mrdata = backing[t_a];
        mem_active = 1'b0;
      end
    end
  end

  // Monitor: pops expectations when a CPU access completes or a memory request starts.
  initial begin
    int       stall_cnt;
    logic     prev_mr;
    logic     prev_mw;
    cpu_exp_t ce;
    mem_exp_t me;
    stall_cnt = 0; prev_mr = 1'b0; prev_mw = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_cnt = 0;
      end else if (rd || wr) begin
        if (busywait) begin
          stall_cnt++;
        end else begin
          if (cpu_q.size() == 0) begin
            check("cpu_unexpected_completion", 32'd1, 32'd0);
          end else begin
            ce = cpu_q.pop_front();
            if (ce.chk) check("readdata", {24'd0, readdata}, {24'd0, ce.data});
            check("stall_cycles", stall_cnt, ce.stall);
          end
          stall_cnt = 0;
        end
      end
      if ((mr && !prev_mr) || (mw && !prev_mw)) begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected_request", 32'd1, 32'd0);
        end else begin
          me = mem_q.pop_front();
          check("mem_is_write", {31'd0, mw}, {31'd0, me.is_wr});
          check("mem_address", {26'd0, maddr}, {26'd0, me.addr});
          if (me.is_wr) check("mem_writedata", mwdata, me.wdata);
        end
      end
      if (mr || mw) check("mem_rd_wr_exclusive", {31'd0, mr && mw}, 32'd0);
      prev_mr = mr;
      prev_mw = mw;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; failures = 0;
    pre_idle = 0; busy_len = 5;
    for (int i = 0; i < 64; i++) backing[i] = 32'h0;
    backing[6'h09] = 32'h44332211;
    backing[6'h39] = 32'h88776655;
    backing[6'h04] = 32'hDDCCBBAA;
    backing[6'h24] = 32'h11223344;
    backing[6'h0F] = 32'hCAFEF00D;

    // Reset with a pending load: BUSYWAIT must stay low, outputs cleared.
    rst_n = 1'b0; rd = 1'b1; wr = 1'b0; addr = 8'h25; wdata = 8'h00;
    @(posedge clk); #2;
    @(negedge clk);
    check("reset_busywait", {31'd0, busywait}, 32'd0);
    check("reset_mem_read", {31'd0, mr}, 32'd0);
    check("reset_mem_write", {31'd0, mw}, 32'd0);
    check("reset_readdata", {24'd0, readdata}, 32'd0);
    @(posedge clk); #2;
    rd = 1'b0; rst_n = 1'b1;

    // 1: clean read miss, 5 busy cycles
    exp_mem(1'b0, 6'h09, 32'h0);
    cpu_op(1'b1, 1'b0, 8'h25, 8'h00, 8'h22, 8);
    // 2: write hit then same-cycle read hit
    cpu_op(1'b0, 1'b1, 8'h24, 8'hAB, 8'h00, 0);
    cpu_op(1'b1, 1'b0, 8'h24, 8'h00, 8'hAB, 0);
    // 3: dirty eviction on same index
    exp_mem(1'b1, 6'h09, 32'h443322AB);
    exp_mem(1'b0, 6'h39, 32'h0);
    cpu_op(1'b1, 1'b0, 8'hE4, 8'h00, 8'h55, 14);
    // 4: write miss to clean line merges after fill
    exp_mem(1'b0, 6'h04, 32'h0);
    cpu_op(1'b0, 1'b1, 8'h10, 8'h5A, 8'h00, 8);
    cpu_op(1'b1, 1'b0, 8'h13, 8'h00, 8'hDD, 0);
    cpu_op(1'b1, 1'b0, 8'h10, 8'h00, 8'h5A, 0);
    // evict the merged line, then re-read it from memory
    exp_mem(1'b1, 6'h04, 32'hDDCCBB5A);
    exp_mem(1'b0, 6'h24, 32'h0);
    cpu_op(1'b1, 1'b0, 8'h92, 8'h00, 8'h22, 14);
    exp_mem(1'b0, 6'h04, 32'h0);
    cpu_op(1'b1, 1'b0, 8'h10, 8'h00, 8'h5A, 8);
    // READ and WRITE together: write wins
    cpu_op(1'b1, 1'b1, 8'h11, 8'h77, 8'h00, 0);
    cpu_op(1'b1, 1'b0, 8'h11, 8'h00, 8'h77, 0);

    // 5: reset mid-FETCH
    exp_mem(1'b0, 6'h09, 32'h0);
    rd = 1'b1; addr = 8'h25;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mr && n < 20);
    check("fetch_started", {31'd0, mr}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("busywait_in_reset", {31'd0, busywait}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1; rd = 1'b0;
    @(negedge clk);
    check("mem_read_after_reset", {31'd0, mr}, 32'd0);
    check("readdata_after_reset", {24'd0, readdata}, 32'd0);
    n = 0;
    while (mem_active && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("mem_model_idle", {31'd0, mem_active}, 32'd0);
    @(posedge clk); #2;
    exp_mem(1'b0, 6'h09, 32'h0);
    cpu_op(1'b1, 1'b0, 8'h25, 8'h00, 8'h22, 8);
    // dirty 0x77 was lost by reset; line must miss again
    exp_mem(1'b0, 6'h04, 32'h0);
    cpu_op(1'b1, 1'b0, 8'h11, 8'h00, 8'hBB, 8);

    // 6: memory idle for 2 cycles before going busy
    pre_idle = 2; busy_len = 3;
    exp_mem(1'b0, 6'h0F, 32'h0);
    cpu_op(1'b1, 1'b0, 8'h3D, 8'h00, 8'hF0, 8);
    pre_idle = 0; busy_len = 5;

    repeat (3) @(posedge clk);
    check("cpu_queue_drained", cpu_q.size(), 32'd0);
    check("mem_queue_drained", mem_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
